// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD definitions for the digit-entry and display paths
package bcd_pkg;

   // Entry FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_CHECK = 2'd2,
      ST_OUT   = 2'd3
   } bcd_state_e;

   // Largest legal BCD digit value
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   // Ceiling log2; returns 0 for values <= 1
   function automatic int clog2(input longint value);
      longint v;
      int     r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

   // 10 raised to n
   function automatic longint pow10(input int n);
      longint p;
      p = 1;
      for (int i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

   // Accumulator width able to hold any ndig-digit decimal value
   function automatic int acc_width(input int ndig);
      return clog2(pow10(ndig));
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10 + digit step for BCD-to-binary conversion
module bcd_mac10 #(
   parameter int ACC_W = 7
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [3:0]       digit_i,
   output logic [ACC_W-1:0] acc_o
);

   // Multiply by ten as (acc<<3)+(acc<<1) so no multiplier is inferred
   always_comb begin
      acc_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
   end

endmodule

// File: rtl/bcd_bin_entry.sv
// rtl/bcd_bin_entry.sv - serial BCD digit entry, conversion to binary and range check
// Optional build macro: BCD_AUTO_COMMIT_EN (start conversion as soon as the buffer fills)
module bcd_bin_entry
   import bcd_pkg::*;
#(
   parameter int NDIG    = 2,
   parameter int BIN_W   = 6,
   parameter int MAX_VAL = 59
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clear,
   input  logic                                 digit_valid,
   input  logic [3:0]                           digit,
   output logic                                 digit_ready,
   input  logic                                 commit,
   output logic                                 bin_valid,
   output logic [BIN_W-1:0]                     bin,
   input  logic                                 bin_ready,
   output logic                                 err,
   output logic [clog2(longint'(NDIG + 1))-1:0] ndig_cnt
);

   localparam int CNT_W = clog2(longint'(NDIG + 1));
   localparam int ACC_W = acc_width(NDIG);

   bcd_state_e                state_q, state_d;
   logic [NDIG-1:0][3:0]      buf_q, buf_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]          idx_q, idx_d;
   logic [ACC_W-1:0]          acc_q, acc_d;
   logic [BIN_W-1:0]          bin_q, bin_d;
   logic                      bin_valid_q, bin_valid_d;
   logic                      err_q, err_d;
   logic [3:0]                digit_sel;
   logic [ACC_W-1:0]          acc_next;

   // Pick the digit to fold in next; oldest digit sits at index idx_q-1
   always_comb begin
      digit_sel = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == CNT_W'(i + 1)) begin
            digit_sel = buf_q[i];
         end
      end
   end

   bcd_mac10 #(
      .ACC_W (ACC_W)
   ) u_mac10 (
      .acc_i   (acc_q),
      .digit_i (digit_sel),
      .acc_o   (acc_next)
   );

   // Next-state logic: entry, conversion, range check, output handshake
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      bin_d       = bin_q;
      bin_valid_d = bin_valid_q;
      err_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (digit_valid) begin
               if (digit > BCD_MAX_DIGIT) begin
                  err_d = 1'b1;
               end else if (cnt_q == CNT_W'(NDIG)) begin
                  err_d = 1'b1;
               end else begin
                  for (int i = NDIG - 1; i > 0; i--) begin
                     buf_d[i] = buf_q[i-1];
                  end
                  buf_d[0] = digit;
                  cnt_d    = cnt_q + CNT_W'(1);
               end
            end
            // A coincident legal digit is already counted in cnt_d, so commit includes it
`ifdef BCD_AUTO_COMMIT_EN
            if ((commit && (cnt_d != '0)) ||
                ((cnt_d == CNT_W'(NDIG)) && (cnt_q != CNT_W'(NDIG)))) begin
`else
            if (commit && (cnt_d != '0)) begin
`endif
               acc_d   = '0;
               idx_d   = cnt_d;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            acc_d = acc_next;
            idx_d = idx_q - CNT_W'(1);
            if (idx_q == CNT_W'(1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (acc_q <= ACC_W'(MAX_VAL)) begin
               bin_d       = BIN_W'(acc_q);
               bin_valid_d = 1'b1;
               state_d     = ST_OUT;
            end else begin
               err_d   = 1'b1;
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (bin_ready) begin
               bin_valid_d = 1'b0;
               buf_d       = '0;
               cnt_d       = '0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything, including a completing handshake
      if (clear) begin
         state_d     = ST_IDLE;
         buf_d       = '0;
         cnt_d       = '0;
         idx_d       = '0;
         bin_valid_d = 1'b0;
         err_d       = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         bin_q       <= bin_d;
         bin_valid_q <= bin_valid_d;
         err_q       <= err_d;
      end
   end

   assign digit_ready = (state_q == ST_IDLE);
   assign bin_valid   = bin_valid_q;
   assign bin         = bin_q;
   assign err         = err_q;
   assign ndig_cnt    = cnt_q;

endmodule

// File: tb/tb_bcd_bin_entry.sv
// tb/tb_bcd_bin_entry.sv - scoreboard testbench for bcd_bin_entry
module tb_bcd_bin_entry;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       commit = 1'b0;
   logic       bin_ready = 1'b1;
   logic       digit_ready;
   logic       bin_valid;
   logic [5:0] bin;
   logic       err;
   logic [1:0] ndig_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int err_seen = 0;
   int e0;
   int exp_q[$];
   logic stable;

   bcd_bin_entry #(
      .NDIG    (2),
      .BIN_W   (6),
      .MAX_VAL (59)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_ready (digit_ready),
      .commit      (commit),
      .bin_valid   (bin_valid),
      .bin         (bin),
      .bin_ready   (bin_ready),
      .err         (err),
      .ndig_cnt    (ndig_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_digit(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic send_digit_commit(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      commit      = 1'b1;
      tick();
      digit_valid = 1'b0;
      commit      = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   task automatic wait_bv(input string tag);
      int n = 0;
      while (bin_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, bin_valid, 1);
   endtask

   // Monitor: pop scoreboard on handshake, count err pulses, err vs bin_valid rise
   initial begin
      logic bv_prev;
      bv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (err === 1'b1) err_seen++;
            if (bin_valid && !bv_prev) chk("err_on_bv_rise", err, 0);
            if (bin_valid && bin_ready && !clear) begin
               if (exp_q.size() == 0) chk("result_expected", exp_q.size(), 1);
               else chk("result", bin, exp_q.pop_front());
            end
         end
         bv_prev = bin_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("rst_bv", bin_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", ndig_cnt, 0);
      chk("rst_bin", bin, 0);
      chk("rst_ready", digit_ready, 1);
      rst_n = 1'b1;
      tick();

      // 4,2 -> 42 with latency check
      exp_q.push_back(42);
      send_digit(4'd4);
      send_digit(4'd2);
      chk("t1_cnt", ndig_cnt, 2);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      tick();
      tick();
      chk("t1_lat_early", bin_valid, 0);
      tick();
      chk("t1_lat", bin_valid, 1);
      chk("t1_bin", bin, 42);
      chk("t1_err", err, 0);
      tick();
      chk("t1_bv_drop", bin_valid, 0);
      chk("t1_cnt_clr", ndig_cnt, 0);

      // 7,5 -> 75 out of range
      e0 = err_seen;
      send_digit(4'd7);
      send_digit(4'd5);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      tick();
      tick();
      tick();
      chk("t2_err_pulse", err, 1);
      chk("t2_bv", bin_valid, 0);
      chk("t2_cnt", ndig_cnt, 0);
      tick();
      chk("t2_err_once", err_seen - e0, 1);
      chk("t2_ready", digit_ready, 1);

      // bad digit, full buffer -> 31
      e0 = err_seen;
      exp_q.push_back(31);
      send_digit(4'hC);
      chk("t3_err_bad_digit", err, 1);
      send_digit(4'd3);
      send_digit(4'd1);
      send_digit(4'd8);
      pulse_commit();
      wait_bv("t3_bv");
      tick();
`ifdef BCD_AUTO_COMMIT_EN
      chk("t3_errs", err_seen - e0, 1);
`else
      chk("t3_errs", err_seen - e0, 2);
`endif
      chk("t3_cnt", ndig_cnt, 0);

      // stalled output holds stable and ignores digits/commits
      bin_ready = 1'b0;
      exp_q.push_back(25);
      send_digit(4'd2);
      send_digit(4'd5);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      wait_bv("t4_bv");
      e0 = err_seen;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         digit_valid = 1'b1;
         digit       = 4'd7;
         commit      = 1'b1;
         tick();
         if (bin !== 6'd25 || bin_valid !== 1'b1) stable = 1'b0;
      end
      digit_valid = 1'b0;
      commit      = 1'b0;
      chk("t4_stable", stable, 1);
      chk("t4_cnt", ndig_cnt, 2);
      chk("t4_ready", digit_ready, 0);
      chk("t4_no_err", err_seen - e0, 0);
      bin_ready = 1'b1;
      tick();
      chk("t4_bv_drop", bin_valid, 0);

      // clear during conversion
      e0 = err_seen;
      send_digit(4'd4);
      send_digit(4'd4);
      pulse_commit();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5a_cnt", ndig_cnt, 0);
      chk("t5a_ready", digit_ready, 1);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bin_valid !== 1'b0) stable = 1'b0;
      end
      chk("t5a_no_bv", stable, 1);
      chk("t5a_no_err", err_seen - e0, 0);

      // clear coincident with bin_ready in output state
      bin_ready = 1'b0;
      send_digit(4'd3);
      send_digit(4'd3);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      wait_bv("t5b_bv");
      clear     = 1'b1;
      bin_ready = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5b_bv", bin_valid, 0);
      chk("t5b_cnt", ndig_cnt, 0);
      tick();
      chk("t5b_bv2", bin_valid, 0);
      chk("t5b_no_err", err_seen - e0, 0);

      // 5,9 without commit
`ifdef BCD_AUTO_COMMIT_EN
      exp_q.push_back(59);
      send_digit(4'd5);
      send_digit(4'd9);
      tick();
      tick();
      chk("t6_lat_early", bin_valid, 0);
      tick();
      chk("t6_bv", bin_valid, 1);
      chk("t6_bin", bin, 59);
      tick();
`else
      send_digit(4'd5);
      send_digit(4'd9);
      repeat (5) tick();
      chk("t6_no_bv", bin_valid, 0);
      chk("t6_cnt", ndig_cnt, 2);
      send_digit(4'd1);
      chk("t6_full_err", err, 1);
      chk("t6_cnt_full", ndig_cnt, 2);
      exp_q.push_back(59);
      pulse_commit();
      wait_bv("t6_bv");
      tick();
`endif

      // leading zero, single digit
      exp_q.push_back(7);
      send_digit(4'd0);
      send_digit(4'd7);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      wait_bv("t7_lead0_bv");
      tick();
      exp_q.push_back(8);
      send_digit(4'd8);
      pulse_commit();
      wait_bv("t7_single_bv");
      tick();

      // 60 just above range
      e0 = err_seen;
      send_digit(4'd6);
      send_digit(4'd0);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      repeat (5) tick();
      chk("t7_60_err", err_seen - e0, 1);

      // commit with empty buffer is ignored
      e0 = err_seen;
      pulse_commit();
      tick();
      tick();
      chk("t7_empty_err", err_seen - e0, 0);
      chk("t7_empty_ready", digit_ready, 1);
      chk("t7_empty_bv", bin_valid, 0);

      // digit and commit in the same cycle
      exp_q.push_back(13);
      send_digit(4'd1);
      send_digit_commit(4'd3);
      wait_bv("t8_bv13");
      tick();
      exp_q.push_back(6);
      send_digit_commit(4'd6);
      wait_bv("t8_bv6");
      tick();

      // async reset mid-conversion
      send_digit(4'd1);
      send_digit(4'd2);
`ifndef BCD_AUTO_COMMIT_EN
      pulse_commit();
`endif
      rst_n = 1'b0;
      #2;
      chk("t9_rst_cnt", ndig_cnt, 0);
      chk("t9_rst_ready", digit_ready, 1);
      chk("t9_rst_bv", bin_valid, 0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("t9_after_bv", bin_valid, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
